// File: rtl/cell_msg_pkg.sv
// Shared definitions for the cell message interface.
// Contents: message width and field offsets, opcodes and response codes,
// the endpoint FSM state type, and the neighbour-offset table used by the scan.
package cell_msg_pkg;

  localparam int unsigned AW_DEFAULT = 4;
  localparam int unsigned STATUS_W   = 4;
  localparam int unsigned ST_LSB     = 0;
  localparam int unsigned J_LSB      = 5;

  // Message layout is {i, 1'b0, j, 1'b0, status[3:0]}
  function automatic int unsigned msg_w(input int unsigned aw);
    return 2 * (aw + 1) + 4;
  endfunction

  function automatic int unsigned i_lsb(input int unsigned aw);
    return aw + 6;
  endfunction

  localparam int unsigned MSG_W_DEFAULT = 2 * (AW_DEFAULT + 1) + 4;
  localparam logic [MSG_W_DEFAULT-1:0] MSG_IDLE_DEFAULT = '1;

  localparam logic [3:0] OP_REVEAL    = 4'h0;
  localparam logic [3:0] RSP_MINE     = 4'h9;
  localparam logic [3:0] OP_SET_MINE  = 4'hA;
  localparam logic [3:0] OP_CLR_MINE  = 4'hB;
  localparam logic [3:0] OP_CLEAR_ALL = 4'hC;
  localparam logic [3:0] RSP_CLEARED  = 4'hD;
  localparam logic [3:0] RSP_ERROR    = 4'hE;
  localparam logic [3:0] OP_IDLE      = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_SCAN,
    S_REPLY,
    S_TXDROP
  } state_e;

  // Row offset of neighbour idx: 0-2 above, 3-4 same row, 5-7 below
  function automatic logic signed [1:0] nb_di(input logic [2:0] idx);
    if (idx < 3'd3)      return -2'sd1;
    else if (idx < 3'd5) return 2'sd0;
    else                 return 2'sd1;
  endfunction

  // Column offset of neighbour idx
  function automatic logic signed [1:0] nb_dj(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd3, 3'd5: return -2'sd1;
      3'd1, 3'd6:       return 2'sd0;
      default:          return 2'sd1;
    endcase
  endfunction

endpackage

// File: rtl/cell_msg_endpoint_mine_map.sv
// N x N mine bitmap.
// Ports: clk, rst (sync, active-high), single-bit write port (we/wdata/wi/wj),
// clr_i synchronous clear-all, two combinational read ports (ri0/rj0 -> rd0,
// ri1/rj1 -> rd1). Out-of-range reads return 0; out-of-range writes are dropped.
module cell_msg_endpoint_mine_map #(
  parameter int unsigned N  = 16,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic          wdata_i,
  input  logic [AW-1:0] wi_i,
  input  logic [AW-1:0] wj_i,
  input  logic          clr_i,
  input  logic [AW-1:0] ri0_i,
  input  logic [AW-1:0] rj0_i,
  output logic          rd0_o,
  input  logic [AW-1:0] ri1_i,
  input  logic [AW-1:0] rj1_i,
  output logic          rd1_o
);

  logic [N-1:0] map_q [N];

  logic wr_in, rd0_in, rd1_in;
  assign wr_in  = (32'(wi_i) < N) && (32'(wj_i) < N);
  assign rd0_in = (32'(ri0_i) < N) && (32'(rj0_i) < N);
  assign rd1_in = (32'(ri1_i) < N) && (32'(rj1_i) < N);

  assign rd0_o = rd0_in ? map_q[ri0_i][rj0_i] : 1'b0;
  assign rd1_o = rd1_in ? map_q[ri1_i][rj1_i] : 1'b0;

  // Clear-all has priority over the single-bit write
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      for (int r = 0; r < int'(N); r++) map_q[r] <= '0;
    end else if (we_i && wr_in) begin
      map_q[wi_i][wj_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/cell_msg_endpoint.sv
// Grid-side responder on the cell message interface.
// Ports: clk, rst (sync, active-high); rxmessage/ack_rxmessage command channel
// (four-phase, buffer initiates); txmessage/ack_txmessage reply channel
// (four-phase). All-ones on either message bus means "no message".
module cell_msg_endpoint
  import cell_msg_pkg::*;
#(
  parameter  int unsigned N          = 16,
  parameter  int unsigned ADDR_WIDTH = 4,
  localparam int unsigned MSG_W      = 2 * (ADDR_WIDTH + 1) + 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MSG_W-1:0] rxmessage,
  output logic             ack_rxmessage,
  output logic [MSG_W-1:0] txmessage,
  input  logic             ack_txmessage
);

  localparam int unsigned AW    = ADDR_WIDTH;
  localparam int unsigned CW    = AW + 2;
  localparam int unsigned I_LSB = i_lsb(AW);
  localparam logic [MSG_W-1:0] IDLE_MSG = '1;

  state_e           state_q, state_d;
  logic [AW-1:0]    i_q, i_d, j_q, j_d;
  logic [3:0]       op_q, op_d, cnt_q, cnt_d, res_q, res_d, cnt_sum;
  logic [2:0]       idx_q, idx_d;
  logic             ack_rx_q, ack_rx_d;
  logic [MSG_W-1:0] tx_q, tx_d;

  logic map_we, map_wdata, map_clr, centre_mine, nb_mine;

  // Pad bits of an incoming command carry no information
  logic unused_pad;
  assign unused_pad = rxmessage[J_LSB-1] ^ rxmessage[I_LSB-1];

  logic in_range;
  assign in_range = (32'(i_q) < N) && (32'(j_q) < N);

  // Current neighbour coordinate, widened and signed so off-grid is detectable
  logic signed [CW-1:0] di_ext, dj_ext, ni, nj;
  logic                 nb_on_grid;
  assign di_ext     = CW'(nb_di(idx_q));
  assign dj_ext     = CW'(nb_dj(idx_q));
  assign ni         = $signed({2'b00, i_q}) + di_ext;
  assign nj         = $signed({2'b00, j_q}) + dj_ext;
  assign nb_on_grid = !ni[CW-1] && !nj[CW-1] &&
                      (ni < $signed(CW'(N))) && (nj < $signed(CW'(N)));

  cell_msg_endpoint_mine_map #(.N(N), .AW(AW)) u_map (
    .clk     (clk),
    .rst     (rst),
    .we_i    (map_we),
    .wdata_i (map_wdata),
    .wi_i    (i_q),
    .wj_i    (j_q),
    .clr_i   (map_clr),
    .ri0_i   (i_q),
    .rj0_i   (j_q),
    .rd0_o   (centre_mine),
    .ri1_i   (ni[AW-1:0]),
    .rj1_i   (nj[AW-1:0]),
    .rd1_o   (nb_mine)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      res_q    <= '0;
      ack_rx_q <= 1'b0;
      tx_q     <= IDLE_MSG;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      res_q    <= res_d;
      ack_rx_q <= ack_rx_d;
      tx_q     <= tx_d;
    end
  end

  // Next-state, map control and reply formation
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    res_d     = res_q;
    ack_rx_d  = ack_rx_q;
    tx_d      = tx_q;
    map_we    = 1'b0;
    map_wdata = 1'b0;
    map_clr   = 1'b0;
    cnt_sum   = cnt_q + 4'(nb_on_grid & nb_mine);

    // Rx acknowledge drops as soon as the initiator withdraws, in any state
    if (rxmessage == IDLE_MSG) ack_rx_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = IDLE_MSG;
        if (!ack_rx_q && (rxmessage != IDLE_MSG)) begin
          i_d      = rxmessage[I_LSB +: AW];
          j_d      = rxmessage[J_LSB +: AW];
          op_d     = rxmessage[ST_LSB +: STATUS_W];
          ack_rx_d = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        res_d   = RSP_ERROR;
        state_d = S_REPLY;
        if (op_q == OP_CLEAR_ALL) begin
          map_clr = 1'b1;
          res_d   = RSP_CLEARED;
        end else if (in_range) begin
          case (op_q)
            OP_REVEAL: begin
              cnt_d   = '0;
              idx_d   = '0;
              state_d = S_SCAN;
            end
            OP_SET_MINE: begin
              map_we    = 1'b1;
              map_wdata = 1'b1;
              state_d   = S_IDLE;
            end
            OP_CLR_MINE: begin
              map_we  = 1'b1;
              state_d = S_IDLE;
            end
            default: ;
          endcase
        end
      end
      S_SCAN: begin
        cnt_d = cnt_sum;
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          res_d   = centre_mine ? RSP_MINE : cnt_sum;
          state_d = S_REPLY;
        end
      end
      S_REPLY: begin
        tx_d = {i_q, 1'b0, j_q, 1'b0, res_q};
        // Only leave once the reply has actually been on the bus
        if (ack_txmessage && (tx_q != IDLE_MSG)) state_d = S_TXDROP;
      end
      S_TXDROP: begin
        tx_d = IDLE_MSG;
        if (!ack_txmessage) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ack_rxmessage = ack_rx_q;
  assign txmessage     = tx_q;

endmodule
